// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcode values, arbiter FSM
// states and the operand pattern that makes MOV read back the parity flag.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_LDR  = 3'd0;
    localparam logic [2:0] OP_STR  = 3'd1;
    localparam logic [2:0] OP_ADDR = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_MOV  = 3'd4;
    localparam logic [2:0] OP_LS   = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_BR   = 3'd7;

    localparam logic [3:0] MOV_PARITY_SEL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLAGS = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant for the first requester at
// or after the pointer, wrapping around the requester count.
module rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             valid_o
);

    // Scan offsets 0..N_REQ-1 from the pointer; the first asserted request wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!valid_o && (j == ((int'(ptr_i) + i) % N_REQ)) && req_i[j]) begin
                    gnt_o[j] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: grant, issue, then collect the
// ALU's registered flags and return the result with a one-cycle done pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0][2:0]   cmd_i,
    input  logic [N_REQ-1:0][W-1:0] a_i,
    input  logic [N_REQ-1:0][W-1:0] b_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        done_o,
    output logic [W-1:0]            rslt_o,
    output logic                    pari_o,
    output logic                    zero_o,
    output logic                    busy_o,
    output logic [2:0]              alu_cmd_o,
    output logic [W-1:0]            alu_a_o,
    output logic [W-1:0]            alu_b_o,
    input  logic [W-1:0]            alu_rslt_i,
    input  logic                    alu_pari_i,
    input  logic                    alu_zero_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [N_REQ-1:0] owner_q;
    logic [2:0]       cmd_q;
    logic [W-1:0]     a_q, b_q, rslt_q;
    logic             pari_q, zero_q;

    logic [N_REQ-1:0] pick_gnt;
    logic             pick_valid;
    logic [2:0]       sel_cmd;
    logic [W-1:0]     sel_a, sel_b;
    logic [PTR_W-1:0] owner_idx, next_ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel_cmd   = '0;
        sel_a     = '0;
        sel_b     = '0;
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_cmd = sel_cmd | cmd_i[i];
                sel_a   = sel_a | a_i[i];
                sel_b   = sel_b | b_i[i];
            end
            if (owner_q[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
        next_ptr = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = FLAGS;
            FLAGS:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ALU-drive registers only change on a grant, so while idle the ALU
    // keeps evaluating the last op and its parity flag stays valid for MOV.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cmd_q    <= OP_BR;
            a_q      <= '0;
            b_q      <= '0;
            rslt_q   <= '0;
            pari_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_gnt;
                        cmd_q   <= sel_cmd;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                    end
                end
                ISSUE: rslt_q <= alu_rslt_i;
                FLAGS: begin
                    pari_q   <= alu_pari_i;
                    zero_q   <= alu_zero_i;
                    rr_ptr_q <= next_ptr;
                end
                default: ;
            endcase
        end
    end

    // Flags come straight from the ALU during FLAGS so they line up with done_o.
    always_comb begin
        gnt_o  = '0;
        done_o = '0;
        busy_o = (state_q != IDLE);
        pari_o = pari_q;
        zero_o = zero_q;
        if (state_q == ISSUE) begin
            gnt_o = owner_q;
        end
        if (state_q == FLAGS) begin
            done_o = owner_q;
            pari_o = alu_pari_i;
            zero_o = alu_zero_i;
        end
    end

    assign rslt_o    = rslt_q;
    assign alu_cmd_o = cmd_q;
    assign alu_a_o   = a_q;
    assign alu_b_o   = b_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between N_REQ requesters (fetch/decode unit, load/store helper, debug port).
- Latches one request at a time, drives the ALU opcode/operands, and waits one cycle for the ALU's registered flags.
- Returns the result, parity and zero flag to the owner with a one-cycle done pulse.
- Sits between the requesters and the ALU instance; round-robin fairness.

Parameters:
- N_REQ, 2, number of requesters (legal 2..4).
- W, 8, datapath width; must equal the ALU width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester request level.
- cmd_i  in  N_REQ x 3  per-requester ALU opcode.
- a_i  in  N_REQ x W  per-requester operand A.
- b_i  in  N_REQ x W  per-requester operand B.
- gnt_o  out  N_REQ  one-hot, one-cycle pulse: request latched.
- done_o  out  N_REQ  one-hot, one-cycle pulse: result valid.
- rslt_o  out  W  result of the last completed op.
- pari_o  out  1  parity flag of the last completed op.
- zero_o  out  1  zero flag of the last completed op.
- busy_o  out  1  high whenever state != IDLE.
- alu_cmd_o  out  3  to ALU alu_cmd.
- alu_a_o  out  W  to ALU inA.
- alu_b_o  out  W  to ALU inB.
- alu_rslt_i  in  W  from ALU rslt.
- alu_pari_i  in  1  from ALU pariQ (registered inside the ALU).
- alu_zero_i  in  1  from ALU zeroQ (registered inside the ALU).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=0, gnt_o=0, done_o=0, rslt_o=0, pari_o=0, zero_o=0, busy_o=0.
  - alu_cmd_o=3'b111 (BR), alu_a_o=0, alu_b_o=0.
- FSM states: IDLE -> ISSUE -> FLAGS -> IDLE.
- IDLE:
  - If any req_i is high, pick the first requester at or after rr_ptr (wrapping modulo N_REQ).
  - Latch its cmd/a/b into the ALU-drive registers, pulse gnt_o[k] on the clock edge, record owner=k, go to ISSUE.
  - With no request, hold the ALU-drive registers unchanged, so the ALU flags keep reflecting the last issued op and MOV-from-parity (b[3:0]=4'b1000) chains correctly across requests.
- ISSUE: ALU inputs are stable. At the end of the cycle, capture alu_rslt_i into rslt_o's holding register, then go to FLAGS.
- FLAGS:
  - The ALU flag registers now hold the values for the ISSUE-cycle result.
  - Capture alu_pari_i/alu_zero_i, drive rslt_o/pari_o/zero_o, pulse done_o[owner] for exactly this cycle.
  - Set rr_ptr=(owner+1) mod N_REQ, go to IDLE.
- Latency: request seen in IDLE at edge t -> gnt_o high in cycle t+1 (ISSUE) -> done_o high in cycle t+2 (FLAGS). Next grant earliest at t+3 (one op per 3 cycles).
- Operand capture: operands are sampled only at the grant edge. A requester may change cmd/a/b or drop req_i after gnt_o; this has no effect on the in-flight op.
- Request rules:
  - A requester holds req_i until gnt_o; deasserting earlier withdraws the request.
  - req_i held after done_o is treated as a new request.
- Arbitration:
  - Simultaneous requests are served round-robin; a continuously requesting agent waits at most N_REQ-1 ops.
  - req_i changes during ISSUE/FLAGS are ignored until the next IDLE.
- Outputs between ops: rslt_o/pari_o/zero_o hold the last completed values until the next FLAGS.
- Reset mid-operation: the in-flight op is discarded, no done_o is issued, and all values return to reset.
- Arithmetic: none in this block; width W is pass-through. Overflow and wrap behaviour belong to the ALU.

Decomposition:
- Shared package (e.g. alu_pkg):
  - Opcode constants OP_LDR=0, OP_STR=1, OP_ADDR=2, OP_XOR=3, OP_MOV=4, OP_LS=5, OP_ADDI=6, OP_BR=7.
  - State enum arb_state_t {IDLE, ISSUE, FLAGS}.
  - MOV_PARITY_SEL=4'b1000.
- One sub-module: rr_picker, combinational. Inputs req vector and rr_ptr; outputs a one-hot grant and a valid flag.

Test Plan:
- Reset then single request: req_i=01, cmd=ADDR, a=8'h0F, b=8'h01 -> gnt_o=01 at t+1; done_o=01 at t+2 with rslt_o=8'h10, pari_o=1, zero_o=0; busy_o high for 2 cycles.
- Simultaneous req_i=11 held: requester0 ADDR 8'h80+8'h80, requester1 XOR 8'hAA^8'h55.
  - Grants in order 0,1,0,1 at 3-cycle spacing.
  - done_o=01 with rslt 8'h00, zero_o=1, pari_o=0.
  - done_o=10 with rslt 8'hFF, zero_o=0, pari_o=0.
- Parity chaining: XOR 8'h07^8'h00 (parity 1), idle 5 cycles, then MOV b=8'h08 -> rslt_o=8'h01.
- Operand change after grant: a_i switched from 8'h03 to 8'hFF in the ISSUE cycle, cmd=ADDI b=8'h01 -> rslt_o=8'h04.
- Reset asserted during ISSUE -> no done_o pulse; next cycle all outputs at reset values, alu_cmd_o=3'b111; pending request re-served starting from requester 0.
